// File: rtl/eth_phy_10g_tx_gearbox_pkg.sv
// Shared constants and types for the 66:64 TX gearbox.
package eth_phy_10g_tx_gearbox_pkg;

  localparam int unsigned PayloadWidth  = 64;
  localparam int unsigned SyncHdrWidth  = 2;
  localparam int unsigned BlockWidth    = PayloadWidth + SyncHdrWidth;
  localparam int unsigned GearboxPeriod = 33;
  localparam int unsigned GearboxSlots  = 32;
  localparam int unsigned SeqWidth      = 6;
  // Worst case concatenation is 62 carry bits plus one 66-bit block.
  localparam int unsigned CatWidth      = 2 * PayloadWidth;

  typedef logic [SeqWidth-1:0] seq_t;

  // Carry length in bits for a given sequence index (2 * seq).
  function automatic logic [SeqWidth:0] slot_shift(seq_t seq);
    return {seq, 1'b0};
  endfunction

endpackage

// File: rtl/eth_phy_10g_tx_gearbox_if.sv
// Block stream from the 10GBASE-R TX encoder into the gearbox.
interface eth_phy_10g_tx_gearbox_if;
  import eth_phy_10g_tx_gearbox_pkg::*;

  logic [PayloadWidth-1:0] data;
  logic [SyncHdrWidth-1:0] hdr;
  logic                    valid;
  logic                    ready;

  modport master (
    output data,
    output hdr,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  hdr,
    input  valid,
    output ready
  );

endinterface

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66:64 TX gearbox: packs {data,hdr} blocks into a continuous 64-bit word stream,
// taking 32 blocks per 33 cycles.
module eth_phy_10g_tx_gearbox
  import eth_phy_10g_tx_gearbox_pkg::*;
#(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned HdrWidth    = 2,
  parameter int unsigned OutPipeline = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  eth_phy_10g_tx_gearbox_if.slave in_if,
  output logic [PayloadWidth-1:0] gt_tx_data_o,
  output seq_t                    gt_tx_seq_o,
  output logic                    tx_underflow_o
);

  if (DataWidth != PayloadWidth) begin : gen_bad_data_width
    $fatal(1, "eth_phy_10g_tx_gearbox: DataWidth must be 64");
  end
  if (HdrWidth != SyncHdrWidth) begin : gen_bad_hdr_width
    $fatal(1, "eth_phy_10g_tx_gearbox: HdrWidth must be 2");
  end
  if (OutPipeline > 4) begin : gen_bad_pipeline
    $fatal(1, "eth_phy_10g_tx_gearbox: OutPipeline must be 0..4");
  end

  seq_t                    seq_q, seq_d;
  logic [PayloadWidth-1:0] carry_q, carry_d;
  logic [PayloadWidth-1:0] word_q, word_d;
  seq_t                    word_seq_q;
  logic                    underflow_q, underflow_d;

  logic                    slot_active;
  logic [BlockWidth-1:0]   blk;
  logic [CatWidth-1:0]     cat;
  logic [SeqWidth:0]       shamt;

  assign slot_active = (seq_q < seq_t'(GearboxSlots));
  assign in_if.ready = slot_active && !rst_i;

  always_comb begin
    blk   = in_if.valid ? {in_if.data, in_if.hdr} : '0;
    shamt = slot_shift(seq_q);
    // The block overwrites every carry bit at or above the carry length, so
    // stale bits above the length never reach the line.
    cat                       = '0;
    cat[PayloadWidth-1:0]     = carry_q;
    if (slot_active) begin
      cat[shamt +: BlockWidth] = blk;
    end
    word_d      = cat[PayloadWidth-1:0];
    carry_d     = slot_active ? cat[CatWidth-1:PayloadWidth] : '0;
    underflow_d = slot_active && !in_if.valid;
    seq_d       = (seq_q == seq_t'(GearboxPeriod - 1)) ? '0 : seq_q + seq_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q       <= '0;
      carry_q     <= '0;
      word_q      <= '0;
      word_seq_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      carry_q     <= carry_d;
      word_q      <= word_d;
      word_seq_q  <= seq_q;
      underflow_q <= underflow_d;
    end
  end

  assign tx_underflow_o = underflow_q;

  if (OutPipeline == 0) begin : gen_no_pipe
    assign gt_tx_data_o = word_q;
    assign gt_tx_seq_o  = word_seq_q;
  end else begin : gen_pipe
    (* srl_style = "register" *) logic [PayloadWidth-1:0] data_pipe_q [OutPipeline];
    (* srl_style = "register" *) seq_t                    seq_pipe_q  [OutPipeline];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_pipe_q <= '{default: '0};
        seq_pipe_q  <= '{default: '0};
      end else begin
        data_pipe_q[0] <= word_q;
        seq_pipe_q[0]  <= word_seq_q;
        for (int i = 1; i < OutPipeline; i++) begin
          data_pipe_q[i] <= data_pipe_q[i-1];
          seq_pipe_q[i]  <= seq_pipe_q[i-1];
        end
      end
    end

    assign gt_tx_data_o = data_pipe_q[OutPipeline-1];
    assign gt_tx_seq_o  = seq_pipe_q[OutPipeline-1];
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Bench: a bit-queue model of the line stream checks two gearboxes (no output
// pipeline and a 2-stage output pipeline) every cycle under random traffic.
module tb_eth_phy_10g_tx_gearbox;
  import eth_phy_10g_tx_gearbox_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] gt0, gt2;
  seq_t        seq0, seq2;
  logic        uf0, uf2;

  eth_phy_10g_tx_gearbox_if if0 ();
  eth_phy_10g_tx_gearbox_if if2 ();

  assign if2.data  = if0.data;
  assign if2.hdr   = if0.hdr;
  assign if2.valid = if0.valid;

  eth_phy_10g_tx_gearbox #(.OutPipeline(0)) u_dut0 (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_if          (if0),
    .gt_tx_data_o   (gt0),
    .gt_tx_seq_o    (seq0),
    .tx_underflow_o (uf0)
  );

  eth_phy_10g_tx_gearbox #(.OutPipeline(2)) u_dut2 (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_if          (if2),
    .gt_tx_data_o   (gt2),
    .gt_tx_seq_o    (seq2),
    .tx_underflow_o (uf2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: line as a bit queue. Each accept slot appends 66 bits LSB first,
  // every cycle removes 64 bits as the next line word.
  int          cnt;
  bit          q[$];
  logic [63:0] e0, d1, d2;
  logic [5:0]  es0, ds1, ds2;
  logic        euf;

  task automatic model_edge(input logic r, input logic v, input logic [63:0] d,
                            input logic [1:0] h);
    logic [65:0] blk;
    logic [63:0] w;
    if (r) begin
      cnt = 0;
      q.delete();
      e0 = '0; d1 = '0; d2 = '0;
      es0 = '0; ds1 = '0; ds2 = '0;
      euf = 1'b0;
    end else begin
      d2 = d1; d1 = e0;
      ds2 = ds1; ds1 = es0;
      if (cnt < 32) begin
        blk = v ? {d, h} : 66'b0;
        for (int i = 0; i < 66; i++) q.push_back(blk[i]);
        euf = !v;
      end else begin
        euf = 1'b0;
      end
      w = '0;
      for (int i = 0; i < 64; i++) w[i] = q.pop_front();
      e0  = w;
      es0 = cnt[5:0];
      cnt = (cnt + 1) % 33;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gt_data_p0", gt0, e0);
      chk("gt_seq_p0", 64'(seq0), 64'(es0));
      chk("underflow_p0", 64'(uf0), 64'(euf));
      chk("ready_p0", 64'(if0.ready), 64'(!rst && cnt != 32));
      chk("gt_data_p2", gt2, d2);
      chk("gt_seq_p2", 64'(seq2), 64'(ds2));
      chk("underflow_p2", 64'(uf2), 64'(euf));
      chk("ready_p2", 64'(if2.ready), 64'(!rst && cnt != 32));
    end
  end

  int ready_lows;
  int uf_pulses;

  task automatic cycle(input logic r, input logic v, input logic [63:0] d, input logic [1:0] h,
                       output bit acc);
    rst       = r;
    if0.valid = v;
    if0.data  = d;
    if0.hdr   = h;
    acc = !r && v && (cnt < 32);
    @(posedge clk);
    #1;
    model_edge(r, v, d, h);
    if (!if0.ready) ready_lows++;
    if (uf0) uf_pulses++;
  endtask

  logic [63:0] cur_d;
  logic [1:0]  cur_h;
  bit          acc;

  task automatic new_block();
    cur_d = {$urandom, $urandom};
    cur_h = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, cur_d, cur_h, acc);
  endtask

  initial begin
    rst = 1'b1;
    if0.valid = 1'b0;
    if0.data  = '0;
    if0.hdr   = '0;
    cnt = 0;
    new_block();

    // Constant block stream
    cur_d = 64'h0123_4567_89AB_CDEF;
    cur_h = 2'b01;
    cycle(1'b1, 1'b1, cur_d, cur_h, acc);
    chk_en = 1'b1;
    do_reset(2);
    chk("reset_ready", 64'(if0.ready), 64'd0);
    chk("reset_data", gt0, 64'd0);
    ready_lows = 0;
    uf_pulses  = 0;
    cycle(1'b0, 1'b1, cur_d, cur_h, acc);
    chk("first_word", gt0, 64'h048D_159E_26AF_37BD);
    cycle(1'b0, 1'b1, cur_d, cur_h, acc);
    chk("second_word", gt0, 64'h1234_5678_9ABC_DEF4);
    for (int i = 2; i < 66; i++) cycle(1'b0, 1'b1, cur_d, cur_h, acc);
    chk("const_ready_lows", 64'(ready_lows), 64'd2);
    chk("const_underflows", 64'(uf_pulses), 64'd0);

    // All-ones payload, header 2'b10
    cur_d = '1;
    cur_h = 2'b10;
    do_reset(2);
    cycle(1'b0, 1'b1, cur_d, cur_h, acc);
    chk("ones_word0", gt0, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 1; i < 33; i++) cycle(1'b0, 1'b1, cur_d, cur_h, acc);
    chk("ones_word32", gt0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ones_seq32", 64'(seq0), 64'd32);

    // Single underflow at slot 5
    do_reset(2);
    ready_lows = 0;
    uf_pulses  = 0;
    new_block();
    for (int i = 0; i < 99; i++) begin
      cycle(1'b0, !(i == 5), cur_d, cur_h, acc);
      if (acc) new_block();
    end
    chk("drop_underflows", 64'(uf_pulses), 64'd1);
    chk("drop_ready_lows", 64'(ready_lows), 64'd3);

    // Reset at seq 17 for 3 cycles, then restart
    do_reset(2);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, cur_d, cur_h, acc);
      if (acc) new_block();
    end
    do_reset(3);
    chk("midrst_data", gt0, 64'd0);
    chk("midrst_seq", 64'(seq0), 64'd0);
    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, 1'b1, cur_d, cur_h, acc);
      if (acc) new_block();
    end

    // Random valid gaps
    for (int i = 0; i < 250; i++) begin
      cycle(1'b0, ($urandom_range(0, 9) != 0), cur_d, cur_h, acc);
      if (acc) new_block();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
